ysyx_bus_arbiter: RTL and testbench
===================================

// Module: ysyx_bus_arbiter
// PURPOSE
//  Shares the single memory bus between the IFU (read-only) and the LSU (read/write).
//  Sits between both fetch/load-store units and the memory slave. Arbitrates round-robin
//  and sequences one AXI-lite-style transaction at a time. Reports slave error responses
//  and watchdog timeouts to the requesting master.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  TIMEOUT  255  max cycles in any slave-wait state before abort (8-bit counter)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-low reset (reset when rst==0)
//  ifu_araddr   in   ADDR_W  IFU fetch address
//  ifu_arvalid  in   1       IFU read request (level, may stay high after response)
//  ifu_rdata    out  DATA_W  IFU read data
//  ifu_rvalid   out  1       IFU response pulse
//  lsu_araddr   in   ADDR_W  LSU load address
//  lsu_arvalid  in   1       LSU read request
//  lsu_rdata    out  DATA_W  LSU read data
//  lsu_rvalid   out  1       LSU read response pulse
//  lsu_awaddr   in   ADDR_W  LSU store address
//  lsu_wdata    in   DATA_W  LSU store data
//  lsu_wstrb    in   DATA_W/8 LSU byte strobes
//  lsu_awvalid  in   1       LSU write request (addr+data valid together)
//  lsu_bvalid   out  1       LSU write-done pulse
//  bus_err      out  1       pulse with any response: slave resp!=0 or timeout
//  mem_araddr/mem_arvalid out, mem_arready in; mem_rdata/mem_rresp[2]/mem_rvalid in, mem_rready out
//  mem_awaddr/mem_awvalid out, mem_awready in; mem_wdata/mem_wstrb/mem_wvalid out, mem_wready in
//  mem_bresp[2]/mem_bvalid in, mem_bready out
// BEHAVIOUR
//  - Reset: state=IDLE; all *_valid/ready outputs 0; rdata outputs 0; last_grant=LSU (IFU wins
//    first tie); ifu_hold=lsu_hold=0; timer=0. Reset mid-transaction aborts silently (no pulse).
//  - States: IDLE, IAR, IR, LAR, LR, LAW, LB.
//  - IDLE: eligible_X = X_valid & !X_hold (LSU valid = lsu_arvalid|lsu_awvalid).
//    One eligible -> grant it. Both -> grant the one != last_grant. lsu_awvalid beats
//    lsu_arvalid if both. Grant registers address/data/strb and sets last_grant.
//    Next state IAR/LAR/LAW. Grant takes 1 cycle; mem_*valid asserted from next cycle.
//  - IAR/LAR: mem_arvalid=1 with latched addr; on mem_arready -> IR/LR, arvalid drops same edge.
//  - LAW: mem_awvalid and mem_wvalid both 1; each drops independently on its ready;
//    when both accepted (same or different cycles) -> LB.
//  - IR/LR/LB: mem_rready/mem_bready=1; on mem_rvalid/mem_bvalid: 1-cycle registered pulse
//    on ifu_rvalid/lsu_rvalid/lsu_bvalid next cycle, rdata registered and held until next
//    response to same master; bus_err=|resp; set X_hold; -> IDLE.
//  - Hold: X_hold clears in any cycle X's request is sampled low; prevents re-issuing a
//    request the master has not yet dropped. Hold only masks; never blocks the other master.
//  - Timer: reset to 0 on every state change; increments in non-IDLE states; reaching
//    TIMEOUT -> drop all mem_* valids/readies, pulse response to owner with rdata=0,
//    bus_err=1, set hold, -> IDLE. Late slave responses while IDLE are ignored.
//  - At most one outstanding transaction; min turnaround response->next grant = 1 cycle.
//  - Responses never pulsed to a non-owner; ifu_rvalid and lsu_* pulses mutually exclusive.
// TESTING
//  1 IFU only, addr 0x8000_0000, slave arready/rvalid 1 cycle after request, rdata 0x0000_0413
//    -> ifu_rvalid one pulse, ifu_rdata=0x0000_0413, bus_err=0, no second mem_arvalid
//    while ifu_arvalid stays high 5 more cycles.
//  2 IFU and LSU load raise arvalid same cycle after reset -> IFU granted first, LSU next;
//    repeat tie -> grants alternate IFU,LSU,IFU,LSU.
//  3 LSU store 0x8000_0100, wdata 0xDEADBEEF, wstrb 0xF; awready 2 cycles before wready
//    -> LB entered only after both; lsu_bvalid once; mem_wstrb=0xF.
//  4 Slave returns rresp=2'b10 on LSU load -> lsu_rvalid and bus_err pulse same cycle.
//  5 Slave never asserts rvalid -> after 255 cycles in LR: lsu_rvalid=1, lsu_rdata=0,
//    bus_err=1, state IDLE; IFU pending request granted next cycle.
//  6 rst driven 0 for 1 cycle while in IR -> all outputs 0 next cycle, no ifu_rvalid pulse;
//    IFU request re-granted after rst returns 1.

Source files
------------

// File: rtl/ysyx_bus_arbiter.sv
// Round-robin arbiter sharing one AXI-lite style memory bus between IFU and LSU.
// One transaction in flight; slave errors and watchdog expiry reported as bus_err.
module ysyx_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_awvalid,
    output logic                lsu_bvalid,
    output logic                bus_err,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_IAR  = 3'd1;
    localparam logic [2:0] S_IR   = 3'd2;
    localparam logic [2:0] S_LAR  = 3'd3;
    localparam logic [2:0] S_LR   = 3'd4;
    localparam logic [2:0] S_LAW  = 3'd5;
    localparam logic [2:0] S_LB   = 3'd6;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    // Abort on the edge that would bring the timer to TIMEOUT.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [2:0]          state;
    logic                last_grant;
    logic                ifu_hold;
    logic                lsu_hold;
    logic [7:0]          timer;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done;
    logic                w_done;

    logic ifu_elig;
    logic lsu_elig;
    logic pick_ifu;
    logic aw_ok;
    logic w_ok;
    logic progress;
    logic expired;
    logic owner_ifu;
    logic owner_lsu_rd;

    assign ifu_elig = ifu_arvalid & ~ifu_hold;
    assign lsu_elig = (lsu_arvalid | lsu_awvalid) & ~lsu_hold;
    assign pick_ifu = ifu_elig & (~lsu_elig | (last_grant == GRANT_LSU));

    assign mem_araddr  = addr_q;
    assign mem_awaddr  = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign mem_arvalid = (state == S_IAR) || (state == S_LAR);
    assign mem_rready  = (state == S_IR) || (state == S_LR);
    assign mem_awvalid = (state == S_LAW) && !aw_done;
    assign mem_wvalid  = (state == S_LAW) && !w_done;
    assign mem_bready  = (state == S_LB);

    assign aw_ok   = aw_done | (mem_awvalid & mem_awready);
    assign w_ok    = w_done | (mem_wvalid & mem_wready);
    assign expired = (timer == TIMER_LAST);

    assign owner_ifu    = (state == S_IAR) || (state == S_IR);
    assign owner_lsu_rd = (state == S_LAR) || (state == S_LR);

    always_comb begin
        progress = 1'b0;
        unique case (state)
            S_IAR, S_LAR: progress = mem_arready;
            S_IR, S_LR:   progress = mem_rvalid;
            S_LAW:        progress = aw_ok & w_ok;
            S_LB:         progress = mem_bvalid;
            default:      progress = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= GRANT_LSU;
            ifu_hold   <= 1'b0;
            lsu_hold   <= 1'b0;
            timer      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            ifu_rdata  <= '0;
            lsu_rdata  <= '0;
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_bvalid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_bvalid <= 1'b0;
            bus_err    <= 1'b0;
            if (!ifu_arvalid) ifu_hold <= 1'b0;
            if (!(lsu_arvalid | lsu_awvalid)) lsu_hold <= 1'b0;

            if (state == S_IDLE) begin
                timer <= '0;
                if (pick_ifu) begin
                    state      <= S_IAR;
                    addr_q     <= ifu_araddr;
                    last_grant <= GRANT_IFU;
                end else if (lsu_elig) begin
                    last_grant <= GRANT_LSU;
                    if (lsu_awvalid) begin
                        state   <= S_LAW;
                        addr_q  <= lsu_awaddr;
                        wdata_q <= lsu_wdata;
                        wstrb_q <= lsu_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        state  <= S_LAR;
                        addr_q <= lsu_araddr;
                    end
                end
            end else if (progress) begin
                timer <= '0;
                unique case (state)
                    S_IAR: state <= S_IR;
                    S_LAR: state <= S_LR;
                    S_LAW: state <= S_LB;
                    S_IR: begin
                        state      <= S_IDLE;
                        ifu_rvalid <= 1'b1;
                        ifu_rdata  <= mem_rdata;
                        bus_err    <= |mem_rresp;
                        ifu_hold   <= 1'b1;
                    end
                    S_LR: begin
                        state      <= S_IDLE;
                        lsu_rvalid <= 1'b1;
                        lsu_rdata  <= mem_rdata;
                        bus_err    <= |mem_rresp;
                        lsu_hold   <= 1'b1;
                    end
                    default: begin
                        state      <= S_IDLE;
                        lsu_bvalid <= 1'b1;
                        bus_err    <= |mem_bresp;
                        lsu_hold   <= 1'b1;
                    end
                endcase
            end else if (expired) begin
                // Watchdog: give the owner an error response and free the bus.
                timer   <= '0;
                state   <= S_IDLE;
                bus_err <= 1'b1;
                if (owner_ifu) begin
                    ifu_rvalid <= 1'b1;
                    ifu_rdata  <= '0;
                    ifu_hold   <= 1'b1;
                end else if (owner_lsu_rd) begin
                    lsu_rvalid <= 1'b1;
                    lsu_rdata  <= '0;
                    lsu_hold   <= 1'b1;
                end else begin
                    lsu_bvalid <= 1'b1;
                    lsu_hold   <= 1'b1;
                end
            end else begin
                timer <= timer + 8'd1;
                if (state == S_LAW) begin
                    aw_done <= aw_ok;
                    w_done  <= w_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_bus_arbiter.sv
// Bench for ysyx_bus_arbiter: directed scenarios, then randomized traffic
// checked against a transaction-level round-robin model and a simple slave.
module tb_ysyx_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_awvalid;
    logic        lsu_bvalid;
    logic        bus_err;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_rdata   = '0;
    logic [1:0]  mem_rresp   = '0;
    logic        mem_rvalid  = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_awaddr;
    logic        mem_awvalid;
    logic        mem_awready = 1'b0;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wvalid;
    logic        mem_wready  = 1'b0;
    logic [1:0]  mem_bresp   = '0;
    logic        mem_bvalid  = 1'b0;
    logic        mem_bready;

    ysyx_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_awvalid(lsu_awvalid),
        .lsu_bvalid(lsu_bvalid), .bus_err(bus_err),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid),
        .mem_arready(mem_arready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready), .mem_awaddr(mem_awaddr),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid),
        .mem_bready(mem_bready)
    );

    int checks = 0;
    int errors = 0;

    // Slave configuration and state
    int         ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    logic [1:0] rresp_cfg = '0, bresp_cfg = '0;
    bit         no_resp = 1'b0;
    int         ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit         r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] r_addr = '0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, bready_cyc = -1;
    int aw_hi = 0, w_hi = 0;
    int n_ifu = 0, n_lsur = 0, n_lsub = 0, n_ar_hs = 0, viol = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory slave and pulse monitors, evaluated on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ifu_rvalid) n_ifu = n_ifu + 1;
        if (lsu_rvalid) n_lsur = n_lsur + 1;
        if (lsu_bvalid) n_lsub = n_lsub + 1;
        if (ifu_rvalid && (lsu_rvalid || lsu_bvalid)) viol = viol + 1;
        if (lsu_rvalid && lsu_bvalid) viol = viol + 1;
        if (bus_err && !(ifu_rvalid || lsu_rvalid || lsu_bvalid)) viol = viol + 1;
        if (mem_awvalid) aw_hi = aw_hi + 1;
        if (mem_wvalid) w_hi = w_hi + 1;
        if (mem_bready && bready_cyc < 0) bready_cyc = cyc;

        mem_arready = 1'b0;
        if (mem_arvalid) begin
            if (ar_cnt >= ar_lat) begin
                mem_arready = 1'b1;
                ar_cnt = 0;
                r_pend = 1'b1;
                r_cnt = 0;
                r_addr = mem_araddr;
                n_ar_hs = n_ar_hs + 1;
            end else ar_cnt = ar_cnt + 1;
        end else ar_cnt = 0;

        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        mem_rresp = 2'($urandom);
        if (r_pend && mem_rready && !no_resp) begin
            if (r_cnt >= r_lat) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem_val(r_addr);
                mem_rresp = rresp_cfg;
                r_pend = 1'b0;
            end else r_cnt = r_cnt + 1;
        end

        mem_awready = 1'b0;
        mem_wready = 1'b0;
        if (mem_awvalid) begin
            if (aw_cnt >= aw_lat) begin
                mem_awready = 1'b1;
                aw_cnt = 0;
                aw_got = 1'b1;
                cap_awaddr = mem_awaddr;
                aw_hs_cyc = cyc;
            end else aw_cnt = aw_cnt + 1;
        end else aw_cnt = 0;
        if (mem_wvalid) begin
            if (w_cnt >= w_lat) begin
                mem_wready = 1'b1;
                w_cnt = 0;
                w_got = 1'b1;
                cap_wdata = mem_wdata;
                cap_wstrb = mem_wstrb;
                w_hs_cyc = cyc;
            end else w_cnt = w_cnt + 1;
        end else w_cnt = 0;
        if (aw_got && w_got) begin
            aw_got = 1'b0;
            w_got = 1'b0;
            b_pend = 1'b1;
            b_cnt = 0;
        end

        mem_bvalid = 1'b0;
        mem_bresp = 2'($urandom);
        if (b_pend && mem_bready) begin
            if (b_cnt >= b_lat) begin
                mem_bvalid = 1'b1;
                mem_bresp = bresp_cfg;
                b_pend = 1'b0;
            end else b_cnt = b_cnt + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            tick();
            if (ifu_rvalid || lsu_rvalid || lsu_bvalid) got = 1'b1;
        end
    endtask

    task automatic wait_rready(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            tick();
            if (mem_rready) got = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n0, a0, rr;
        bit exp_ifu, last_lsu, pend_i, pend_l, lsu_wr;
        int sel, kind;

        rst = 1'b0;
        ifu_araddr = '0; ifu_arvalid = 1'b0;
        lsu_araddr = '0; lsu_arvalid = 1'b0;
        lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_awvalid = 1'b0;
        repeat (3) tick();
        chk("rst_valids", 32'({mem_arvalid, mem_rready, mem_awvalid, mem_wvalid,
            mem_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid, bus_err}), 32'd0);
        chk("rst_ifu_rdata", ifu_rdata, 32'd0);
        chk("rst_lsu_rdata", lsu_rdata, 32'd0);
        rst = 1'b1;
        tick();

        // 1: single IFU fetch, request held afterwards
        ar_lat = 1; r_lat = 1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        n0 = n_ifu; a0 = n_ar_hs;
        wait_resp(20, got);
        chk("t1_who", 32'({got, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 32'b1100);
        chk("t1_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_err", 32'(bus_err), 32'd0);
        tick();
        chk("t1_pulse_len", 32'(ifu_rvalid), 32'd0);
        repeat (4) tick();
        chk("t1_ar_count", 32'(n_ar_hs - a0), 32'd1);
        chk("t1_pulses", 32'(n_ifu - n0), 32'd1);
        chk("t1_rdata_hold", ifu_rdata, 32'h0000_0413);
        ifu_arvalid = 1'b0;
        tick();

        // 2: simultaneous requests after reset, then repeated ties
        rst = 1'b0; tick(); rst = 1'b1;
        ar_lat = 0; r_lat = 0;
        ifu_araddr = 32'h8000_0010; lsu_araddr = 32'h8000_0200;
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        wait_resp(20, got);
        chk("t2_first_ifu", 32'({got, ifu_rvalid, lsu_rvalid}), 32'b110);
        chk("t2_ifu_data", ifu_rdata, mem_val(32'h8000_0010));
        ifu_arvalid = 1'b0;
        wait_resp(20, got);
        chk("t2_then_lsu", 32'({got, ifu_rvalid, lsu_rvalid}), 32'b101);
        chk("t2_lsu_data", lsu_rdata, mem_val(32'h8000_0200));
        lsu_arvalid = 1'b0;
        tick(); tick();
        exp_ifu = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ifu_araddr = $urandom; lsu_araddr = $urandom;
            ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
            wait_resp(20, got);
            chk($sformatf("t2_tie%0d", r), 32'({got, ifu_rvalid, lsu_rvalid}),
                exp_ifu ? 32'b110 : 32'b101);
            ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
            tick(); tick();
            exp_ifu = !exp_ifu;
        end

        // 3: LSU store, AW accepted two cycles before W
        aw_lat = 0; w_lat = 2; b_lat = 1; bresp_cfg = 2'b00;
        lsu_awaddr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
        aw_hi = 0; w_hi = 0; bready_cyc = -1; n0 = n_lsub;
        lsu_awvalid = 1'b1;
        wait_resp(30, got);
        chk("t3_who", 32'({got, lsu_bvalid, lsu_rvalid, ifu_rvalid}), 32'b1100);
        chk("t3_err", 32'(bus_err), 32'd0);
        chk("t3_awaddr", cap_awaddr, 32'h8000_0100);
        chk("t3_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("t3_wstrb", 32'(cap_wstrb), 32'hF);
        chk("t3_aw_cycles", 32'(aw_hi), 32'd1);
        chk("t3_w_cycles", 32'(w_hi), 32'd3);
        chk("t3_w_after_aw", 32'(w_hs_cyc - aw_hs_cyc), 32'd2);
        chk("t3_lb_after_both", 32'(bready_cyc - w_hs_cyc), 32'd1);
        lsu_awvalid = 1'b0;
        tick();
        chk("t3_bpulses", 32'(n_lsub - n0), 32'd1);

        // 4: slave error on LSU load
        ar_lat = 0; r_lat = 1; rresp_cfg = 2'b10;
        lsu_araddr = 32'h8000_0300; lsu_arvalid = 1'b1;
        wait_resp(20, got);
        chk("t4_resp_err", 32'({got, lsu_rvalid, bus_err}), 32'b111);
        chk("t4_data", lsu_rdata, mem_val(32'h8000_0300));
        lsu_arvalid = 1'b0; rresp_cfg = 2'b00;
        tick();
        chk("t4_err_len", 32'(bus_err), 32'd0);

        // 5: slave never answers, IFU waiting behind
        no_resp = 1'b1;
        lsu_araddr = 32'h8000_0400; lsu_arvalid = 1'b1;
        wait_rready(20, got);
        chk("t5_in_lr", 32'(got), 32'd1);
        ifu_araddr = 32'h8000_0040; ifu_arvalid = 1'b1;
        rr = 1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (ifu_rvalid || lsu_rvalid || lsu_bvalid) got = 1'b1;
            else if (mem_rready) rr++;
        end
        chk("t5_cycles_in_lr", 32'(rr), 32'd255);
        chk("t5_who", 32'({got, lsu_rvalid, ifu_rvalid, bus_err}), 32'b1101);
        chk("t5_rdata_zero", lsu_rdata, 32'd0);
        chk("t5_idle", 32'(mem_rready), 32'd0);
        no_resp = 1'b0; lsu_arvalid = 1'b0;
        tick();
        chk("t5_ifu_grant", 32'({mem_arvalid, mem_araddr == 32'h8000_0040}), 32'b11);
        wait_resp(20, got);
        chk("t5_ifu_resp", 32'({got, ifu_rvalid}), 32'b11);
        chk("t5_ifu_data", ifu_rdata, mem_val(32'h8000_0040));
        ifu_arvalid = 1'b0;
        tick();

        // 6: reset while waiting in IR
        r_lat = 5;
        ifu_araddr = 32'h8000_0080; ifu_arvalid = 1'b1;
        n0 = n_ifu;
        wait_rready(20, got);
        chk("t6_in_ir", 32'(got), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6_rst_valids", 32'({mem_arvalid, mem_rready, mem_awvalid, mem_wvalid,
            mem_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid, bus_err}), 32'd0);
        chk("t6_rst_rdata", ifu_rdata, 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_no_pulse", 32'(n_ifu - n0), 32'd0);
        chk("t6_regrant", 32'({mem_arvalid, mem_araddr == 32'h8000_0080}), 32'b11);
        wait_resp(30, got);
        chk("t6_resp", 32'({got, ifu_rvalid}), 32'b11);
        chk("t6_data", ifu_rdata, mem_val(32'h8000_0080));
        ifu_arvalid = 1'b0;
        tick();

        // Randomized traffic against a round-robin transaction model
        rst = 1'b0; tick(); rst = 1'b1;
        last_lsu = 1'b1;
        for (int r = 0; r < 40; r++) begin
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            b_lat = $urandom_range(0, 3);
            rresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sel = $urandom_range(1, 3);
            kind = $urandom_range(0, 2);
            ifu_araddr = $urandom; lsu_araddr = $urandom; lsu_awaddr = $urandom;
            lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
            pend_i = sel[0];
            pend_l = sel[1];
            lsu_wr = (kind != 0);
            ifu_arvalid = pend_i;
            lsu_arvalid = pend_l && (kind != 1);
            lsu_awvalid = pend_l && (kind != 0);
            while (pend_i || pend_l) begin
                exp_ifu = pend_i && (!pend_l || last_lsu);
                wait_resp(60, got);
                if (exp_ifu) begin
                    chk($sformatf("rnd%0d_ifu_who", r),
                        32'({got, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 32'b1100);
                    chk($sformatf("rnd%0d_ifu_data", r), ifu_rdata, mem_val(ifu_araddr));
                    chk($sformatf("rnd%0d_ifu_err", r), 32'(bus_err), 32'(|rresp_cfg));
                    ifu_arvalid = 1'b0;
                    pend_i = 1'b0;
                    last_lsu = 1'b0;
                end else if (lsu_wr) begin
                    chk($sformatf("rnd%0d_st_who", r),
                        32'({got, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 32'b1001);
                    chk($sformatf("rnd%0d_st_addr", r), cap_awaddr, lsu_awaddr);
                    chk($sformatf("rnd%0d_st_data", r), cap_wdata, lsu_wdata);
                    chk($sformatf("rnd%0d_st_strb", r), 32'(cap_wstrb), 32'(lsu_wstrb));
                    chk($sformatf("rnd%0d_st_err", r), 32'(bus_err), 32'(|bresp_cfg));
                    lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;
                    pend_l = 1'b0;
                    last_lsu = 1'b1;
                end else begin
                    chk($sformatf("rnd%0d_ld_who", r),
                        32'({got, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 32'b1010);
                    chk($sformatf("rnd%0d_ld_data", r), lsu_rdata, mem_val(lsu_araddr));
                    chk($sformatf("rnd%0d_ld_err", r), 32'(bus_err), 32'(|rresp_cfg));
                    lsu_arvalid = 1'b0; lsu_awvalid = 1'b0;
                    pend_l = 1'b0;
                    last_lsu = 1'b1;
                end
            end
            tick(); tick();
        end

        chk("pulse_exclusive", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
